vector_instr_sequencer: RTL

Synthesizable, parametrised instruction feeder for vector_cpu. It replaces hand-timed instruction pokes with a loadable program buffer and an issue FSM that spaces instructions by a configurable gap. It also has a capture FIFO that records every memory-write event (address plus all lane data) the CPU produces. It sits between a host/bench loader and vector_cpu's instr input and mem-write outputs.

---
 rtl/vector_seq_pkg.sv | 15 +
 rtl/vec_capture_fifo.sv | 52 +++++
 rtl/vector_instr_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vector_seq_pkg.sv
// Shared opcode constants and state encoding for the vector instruction sequencer.
package vector_seq_pkg;

   localparam int OPC_W = 5;
   localparam logic [OPC_W-1:0] OPC_NOP  = 5'b01110;
   localparam logic [OPC_W-1:0] OPC_HALT = 5'b11111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/vec_capture_fifo.sv
// Show-ahead capture FIFO: head entry is always presented while non-empty.
module vec_capture_fifo #(
   parameter int WIDTH = 160,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vector_instr_sequencer.sv
// Program buffer plus issue FSM feeding vector_cpu, with a capture FIFO for its memory writes.
//
//  state   | meaning
//  S_IDLE  | stopped; program buffer loadable, captures ignored
//  S_ISSUE | read mem[ptr]; issue it or stop on HALT
//  S_GAP   | spacing down-counter between issues
//  S_DONE  | program finished; instr held at NOP
module vector_instr_sequencer
   import vector_seq_pkg::*;
#(
   parameter int INSTR_W   = 30,
   parameter int DATA_W    = 32,
   parameter int LANES     = 4,
   parameter int DEPTH     = 16,
   parameter int GAP       = 10,
   parameter int CAP_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          prog_we,
   input  logic [$clog2(DEPTH)-1:0]      prog_addr,
   input  logic [INSTR_W-1:0]            prog_data,
   input  logic                          start,
   input  logic                          abort,
   output logic [INSTR_W-1:0]            instr,
   output logic                          instr_valid,
   input  logic                          mem_wr_enable,
   input  logic [DATA_W-1:0]             wr_addr,
   input  logic [LANES*DATA_W-1:0]       wd,
   input  logic                          cap_rd_en,
   output logic                          cap_valid,
   output logic [DATA_W-1:0]             cap_addr,
   output logic [LANES*DATA_W-1:0]       cap_data,
   output logic [$clog2(CAP_DEPTH):0]    cap_count,
   output logic [$clog2(DEPTH):0]        issued_count,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow
);
   localparam int AW    = $clog2(DEPTH);
   localparam int ENT_W = DATA_W * (LANES + 1);
   localparam int GW    = (GAP > 2) ? $clog2(GAP) : 1;
   // GAP state lasts GAP-1 cycles; counting down to zero from GAP-2 gives that.
   localparam logic [GW-1:0] GAP_LOAD = (GAP > 2) ? GW'(GAP - 2) : '0;
   localparam logic [INSTR_W-1:0] NOP_WORD = {OPC_NOP, {(INSTR_W-OPC_W){1'b0}}};
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [INSTR_W-1:0] pmem [DEPTH];
   seq_state_t         state;
   logic [AW-1:0]      ptr;
   logic [GW-1:0]      gap_cnt;
   logic [INSTR_W-1:0] cur_word;
   logic [OPC_W-1:0]   cur_opc;
   logic               start_run;
   logic               cap_push;
   logic               cap_full;
   logic               cap_empty;
   logic [ENT_W-1:0]   cap_head;

   assign cur_word  = pmem[ptr];
   assign cur_opc   = cur_word[INSTR_W-1 -: OPC_W];
   assign start_run = !abort && start && (state == S_IDLE || state == S_DONE);
   assign cap_push  = mem_wr_enable && (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (prog_we && !busy) pmem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         ptr          <= '0;
         gap_cnt      <= '0;
         instr        <= NOP_WORD;
         instr_valid  <= 1'b0;
         issued_count <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
            instr <= NOP_WORD;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state        <= S_ISSUE;
                     ptr          <= '0;
                     issued_count <= '0;
                     busy         <= 1'b1;
                     done         <= 1'b0;
                  end else if (state == S_DONE) begin
                     instr <= NOP_WORD;
                  end
               end
               S_ISSUE: begin
                  if (cur_opc == OPC_HALT) begin
                     state <= S_DONE;
                     instr <= NOP_WORD;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     instr        <= cur_word;
                     instr_valid  <= 1'b1;
                     issued_count <= issued_count + 1'b1;
                     if (ptr == LAST_PTR) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        ptr <= ptr + 1'b1;
                        if (GAP > 1) begin
                           state   <= S_GAP;
                           gap_cnt <= GAP_LOAD;
                        end
                     end
                  end
               end
               S_GAP: begin
                  if (gap_cnt == '0) state <= S_ISSUE;
                  else               gap_cnt <= gap_cnt - 1'b1;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // A drop in the same cycle as a restart still flags, so no lost capture goes unreported.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                       overflow <= 1'b0;
      else if (cap_push && cap_full && !cap_rd_en)    overflow <= 1'b1;
      else if (start_run)                             overflow <= 1'b0;
   end

   vec_capture_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (CAP_DEPTH)
   ) u_cap_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap_push),
      .pop   (cap_rd_en),
      .wdata ({wr_addr, wd}),
      .rdata (cap_head),
      .count (cap_count),
      .full  (cap_full),
      .empty (cap_empty)
   );

   assign cap_valid = !cap_empty;
   assign cap_addr  = cap_head[ENT_W-1 -: DATA_W];
   assign cap_data  = cap_head[LANES*DATA_W-1:0];

endmodule
